dac_ddr_tx: RTL and testbench



---
 rtl/dac_ddr_pkg.sv | 16 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/dac_ddr_tx.sv | 112 +++++++++++
 tb/tb_dac_ddr_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dac_ddr_pkg.sv
// rtl/dac_ddr_pkg.sv - shared constants and state encoding for the DAC DDR transmit path
package dac_ddr_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LANE_W   = 8;

  localparam logic [SAMPLE_W-1:0] TRAIN_WORD_DEF = 16'hA55A;
  localparam logic [SAMPLE_W-1:0] IDLE_WORD_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRAIN = 2'b01,
    ST_RUN   = 2'b10
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous flush and occupancy output
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Flush wins over a same-edge push so the buffer is truly empty afterwards.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dac_ddr_tx.sv
// rtl/dac_ddr_tx.sv - DDR transmit path: sample FIFO, link-training FSM, registered rise/fall lanes
module dac_ddr_tx
  import dac_ddr_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 8,
  parameter logic [SAMPLE_W-1:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter int                  TRAIN_LEN  = 64,
  parameter logic [SAMPLE_W-1:0] IDLE_WORD  = IDLE_WORD_DEF,
  localparam int                 LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                train_req,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [LANE_W-1:0]   ddr_rise,
  output logic [LANE_W-1:0]   ddr_fall,
  output logic                out_valid,
  output logic [1:0]          state,
  output logic [15:0]         underflow_cnt,
  output logic [LVL_W-1:0]    fifo_level
);

  tx_state_e           state_q, state_d;
  logic [15:0]         train_cnt;
  logic                cnt_clear, cnt_inc;
  logic                fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [SAMPLE_W-1:0] out_word;
  logic                out_v;

  assign s_ready = !rst && !fifo_full;
  assign state   = state_q;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    out_word   = IDLE_WORD;
    out_v      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_TRAIN;
          cnt_clear = 1'b1;
        end
      end
      ST_TRAIN: begin
        out_word = TRAIN_WORD;
        cnt_inc  = 1'b1;
        if (!enable)                           state_d = ST_IDLE;
        else if (train_cnt == 16'(TRAIN_LEN - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Dropping enable beats a retrain request; retrain keeps queued samples.
        if (!enable) begin
          state_d    = ST_IDLE;
          fifo_flush = 1'b1;
        end else if (train_req) begin
          state_d   = ST_TRAIN;
          cnt_clear = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          out_word = fifo_head;
          out_v    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      train_cnt     <= '0;
      ddr_rise      <= IDLE_WORD[LANE_W-1:0];
      ddr_fall      <= IDLE_WORD[SAMPLE_W-1:LANE_W];
      out_valid     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state_q   <= state_d;
      ddr_rise  <= out_word[LANE_W-1:0];
      ddr_fall  <= out_word[SAMPLE_W-1:LANE_W];
      out_valid <= out_v;
      if (cnt_clear)    train_cnt <= '0;
      else if (cnt_inc) train_cnt <= train_cnt + 16'd1;
      if (state_q == ST_RUN && fifo_empty && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_ddr_tx.sv
// tb/tb_dac_ddr_tx.sv - randomized scoreboard bench for dac_ddr_tx against a queue-based reference
module tb_dac_ddr_tx;

  localparam int          FIFO_DEPTH = 8;
  localparam int          TRAIN_LEN  = 64;
  localparam logic [15:0] TRAIN_WORD = 16'hA55A;
  localparam logic [15:0] IDLE_WORD  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, enable, train_req, s_valid, s_ready, out_valid;
  logic [15:0] s_data, underflow_cnt;
  logic [7:0]  ddr_rise, ddr_fall;
  logic [1:0]  state;
  logic [3:0]  fifo_level;

  int n_vec = 0;
  int n_bad = 0;

  dac_ddr_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TRAIN_WORD (TRAIN_WORD),
    .TRAIN_LEN  (TRAIN_LEN),
    .IDLE_WORD  (IDLE_WORD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .train_req     (train_req),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ddr_rise      (ddr_rise),
    .ddr_fall      (ddr_fall),
    .out_valid     (out_valid),
    .state         (state),
    .underflow_cnt (underflow_cnt),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference: mode is 0 idle / 1 train / 2 run; FIFO is a plain queue.
  int          m_mode;
  int          m_trained;
  logic [15:0] m_q[$];
  logic [15:0] sb[$];
  logic [15:0] m_out;
  logic        m_valid;
  int          m_uf;
  logic        rdy_n;

  always @(posedge clk) begin : ref_model
    bit take;
    take = !rst && s_valid && (m_q.size() < FIFO_DEPTH);
    if (rst) begin
      m_mode = 0; m_trained = 0; m_q.delete(); sb.delete();
      m_out = IDLE_WORD; m_valid = 1'b0; m_uf = 0;
    end else begin
      m_out = IDLE_WORD;
      m_valid = 1'b0;
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_trained = 0; end
        1: begin
          m_out = TRAIN_WORD;
          m_trained++;
          if (!enable) m_mode = 0;
          else if (m_trained == TRAIN_LEN) m_mode = 2;
        end
        default: begin
          if (m_q.size() == 0 && m_uf < 65535) m_uf++;
          if (!enable) begin
            m_q.delete(); sb.delete(); take = 1'b0; m_mode = 0;
          end else if (train_req) begin
            m_mode = 1; m_trained = 0;
          end else if (m_q.size() > 0) begin
            m_out = m_q.pop_front(); m_valid = 1'b1;
          end
        end
      endcase
      if (take) begin m_q.push_back(s_data); sb.push_back(s_data); end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] w;
    rdy_n = s_ready;
    check("state", 32'(state), 32'(m_mode));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("s_ready", 32'(s_ready), 32'(!rst && m_q.size() < FIFO_DEPTH));
    check("ddr_rise", 32'(ddr_rise), 32'(m_out[7:0]));
    check("ddr_fall", 32'(ddr_fall), 32'(m_out[15:8]));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) check("sb_unexpected_word", 32'({ddr_fall, ddr_rise}), 32'hFFFF_FFFF);
      else begin
        w = sb.pop_front();
        check("sb_data", 32'({ddr_fall, ddr_rise}), 32'(w));
      end
    end
  end

  logic [15:0] seq_val;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds an offered word until the handshake completes, then picks the next one.
  task automatic drive(input int n, input int pct, input bit seq);
    for (int i = 0; i < n; i++) begin
      step();
      if (s_valid && rdy_n && seq) seq_val++;
      if (!s_valid || rdy_n) begin
        s_valid = ($urandom_range(99) < pct);
        s_data  = seq ? seq_val : 16'($urandom);
      end
    end
  endtask

  task automatic wait_mode(input int target, input int budget);
    int k;
    k = 0;
    while (m_mode != target && k < budget) begin
      drive(1, 0, 0);
      k++;
    end
    if (m_mode != target) check("wait_mode_timeout", 32'(m_mode), 32'(target));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; train_req = 1'b0; s_valid = 1'b0; s_data = '0; seq_val = 16'd1;
    repeat (3) step();
    rst = 1'b0;
    drive(2, 0, 0);

    drive(12, 100, 0);
    check("full_backpressure", 32'(s_ready), 32'(0));

    enable = 1'b1;
    drive(TRAIN_LEN + 25, 0, 0);

    seq_val = 16'd1;
    drive(40, 100, 1);
    drive(12, 0, 0);

    enable = 1'b0; drive(2, 0, 0);
    enable = 1'b1;
    drive(3, 100, 0);
    wait_mode(2, 200);
    train_req = 1'b1; step(); train_req = 1'b0;
    wait_mode(2, 200);
    drive(8, 0, 0);

    enable = 1'b0; drive(2, 0, 0);
    enable = 1'b1;
    drive(10, 100, 0);
    wait_mode(2, 200);
    drive(2, 0, 0);
    enable = 1'b0;
    drive(1, 0, 0);
    check("flush_level", 32'(fifo_level), 32'(0));

    enable = 1'b1;
    drive(TRAIN_LEN + 5, 60, 0);
    rst = 1'b1; drive(2, 0, 0);
    rst = 1'b0; drive(3, 0, 0);

    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(49) != 0);
      train_req = ($urandom_range(29) == 0);
      drive(1, 70, 0);
    end
    train_req = 1'b0;
    drive(4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
